// File: rtl/mac_serial_accumulator.sv
// Serial shift-and-add multiply-accumulate unit.
// Computes a*b (unsigned) one multiplier bit per cycle. It then adds the
// product into a running accumulator, which either wraps or saturates on
// overflow.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - request an operation (sampled only while idle)
//   clear    - zero accumulator and overflow flag
//   a, b     - multiplicand / multiplier, latched on an accepted start
//   busy     - operation in flight
//   done     - one-cycle pulse when acc has been updated
//   acc      - running accumulator
//   overflow - sticky flag, set when an accumulate exceeds the acc range
module mac_serial_accumulator #(
    parameter int unsigned A_WIDTH   = 8,
    parameter int unsigned B_WIDTH   = 4,
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 clear,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 overflow
);

    localparam int unsigned P_WIDTH   = A_WIDTH + B_WIDTH;
    localparam int unsigned CNT_WIDTH = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;
    localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(B_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

    state_t                 state;
    logic [A_WIDTH-1:0]     a_reg;
    logic [B_WIDTH-1:0]     b_reg;
    logic [P_WIDTH-1:0]     product;
    logic [CNT_WIDTH-1:0]   count;

    logic [B_WIDTH-1:0]     b_shift;
    logic [P_WIDTH-1:0]     partial;
    logic [ACC_WIDTH-1:0]   base;
    logic [SUM_WIDTH-1:0]   sum;

    // Current partial product: a shifted to the weight of the multiplier bit being processed
    assign b_shift = b_reg >> count;
    assign partial = b_shift[0] ? (P_WIDTH'(a_reg) << count) : '0;

    // One extra bit on the sum captures the carry that signals overflow
    assign base = clear ? '0 : acc;
    assign sum  = {1'b0, base} + SUM_WIDTH'(product);

    // Control FSM and datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            product  <= '0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                    end
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        product <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    if (clear) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                    end
                    product <= product + partial;
                    count   <= count + CNT_WIDTH'(1);
                    if (count == LAST_BIT) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    // With clear the base is zero, so the sum cannot overflow and the flag clears
                    if (sum[ACC_WIDTH]) begin
                        overflow <= 1'b1;
                        acc      <= (SATURATE != 0) ? '1 : sum[ACC_WIDTH-1:0];
                    end else begin
                        overflow <= clear ? 1'b0 : overflow;
                        acc      <= sum[ACC_WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_serial_accumulator.sv
// Directed bench for mac_serial_accumulator.
// Runs a wrapping and a saturating default-width instance side by side on
// shared stimulus. A separate B_WIDTH=6 / ACC_WIDTH=24 instance checks the
// longer multiply sequence.
module tb_mac_serial_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clear;
    logic [7:0]  a;
    logic [3:0]  b;

    logic        busy_w, done_w, ovf_w;
    logic [15:0] acc_w;
    logic        busy_s, done_s, ovf_s;
    logic [15:0] acc_s;

    logic        start6, clear6;
    logic [7:0]  a6;
    logic [5:0]  b6;
    logic        busy6, done6, ovf6;
    logic [23:0] acc6;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mac_serial_accumulator #(.A_WIDTH(8), .B_WIDTH(4), .ACC_WIDTH(16), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .a(a), .b(b),
        .busy(busy_w), .done(done_w), .acc(acc_w), .overflow(ovf_w)
    );

    mac_serial_accumulator #(.A_WIDTH(8), .B_WIDTH(4), .ACC_WIDTH(16), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .a(a), .b(b),
        .busy(busy_s), .done(done_s), .acc(acc_s), .overflow(ovf_s)
    );

    mac_serial_accumulator #(.A_WIDTH(8), .B_WIDTH(6), .ACC_WIDTH(24), .SATURATE(0)) dut_6 (
        .clk(clk), .rst(rst), .start(start6), .clear(clear6), .a(a6), .b(b6),
        .busy(busy6), .done(done6), .acc(acc6), .overflow(ovf6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one op on the shared pair. Returns the edges from acceptance to done (bounded).
    // With poke set, a (1,1) start is pulsed mid-multiply and must be ignored.
    task automatic do_op(input logic [7:0] av, input logic [3:0] bv, input logic clr,
                         input logic poke, output int lat);
        @(negedge clk);
        a = av; b = bv; start = 1'b1; clear = clr;
        @(posedge clk);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (done_w) break;
            if (lat == 0) check("op_busy", 32'(busy_w), 32'd1);
            clear = 1'b0;
            start = poke && (lat == 2);
            if (poke && lat == 2) begin
                a = 8'd1; b = 4'd1;
            end
            @(posedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic check_pair(input string tag, input int exp_w, input int ov_w,
                              input int exp_s, input int ov_s);
        check({tag, "_acc_w"}, 32'(acc_w), 32'(exp_w));
        check({tag, "_ovf_w"}, 32'(ovf_w), 32'(ov_w));
        check({tag, "_acc_s"}, 32'(acc_s), 32'(exp_s));
        check({tag, "_ovf_s"}, 32'(ovf_s), 32'(ov_s));
    endtask

    task automatic do_op6(input logic [7:0] av, input logic [5:0] bv, output int lat);
        @(negedge clk);
        a6 = av; b6 = bv; start6 = 1'b1;
        @(posedge clk);
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            start6 = 1'b0;
            if (done6) break;
            @(posedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int nd;
        int edges;
        logic seen;

        rst = 1'b0; start = 1'b0; clear = 1'b0; a = '0; b = '0;
        start6 = 1'b0; clear6 = 1'b0; a6 = '0; b6 = '0;

        // Reset takes effect without a clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_acc", 32'(acc_w), 32'd0);
        check("rst_ovf", 32'(ovf_w), 32'd0);
        check("rst_busy", 32'(busy_w), 32'd0);
        check("rst_done", 32'(done_w), 32'd0);
        check("rst_acc6", 32'(acc6), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single op: done after edge B_WIDTH+1, one-cycle pulse
        do_op(8'd255, 4'd15, 1'b0, 1'b0, lat);
        check("single_lat", 32'(lat), 32'd5);
        check("single_busy_at_done", 32'(busy_w), 32'd0);
        check_pair("single", 3825, 0, 3825, 0);
        @(negedge clk);
        check("single_done_drop", 32'(done_w), 32'd0);

        // clear while idle
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("idle_clear", 32'(acc_w), 32'd0);

        // Accumulate sequence, zero operand, clear+start
        do_op(8'd12, 4'd3, 1'b0, 1'b0, lat);
        check("acc1_lat", 32'(lat), 32'd5);
        check_pair("acc1", 36, 0, 36, 0);
        do_op(8'd7, 4'd15, 1'b0, 1'b0, lat);
        check("acc2_lat", 32'(lat), 32'd5);
        check_pair("acc2", 141, 0, 141, 0);
        do_op(8'd0, 4'd9, 1'b0, 1'b0, lat);
        check("zero_lat", 32'(lat), 32'd5);
        check("zero_done", 32'(done_w), 32'd1);
        check_pair("zero", 141, 0, 141, 0);
        do_op(8'd2, 4'd2, 1'b1, 1'b0, lat);
        check_pair("clr_start", 4, 0, 4, 0);

        // start during MUL is ignored
        do_op(8'd255, 4'd15, 1'b1, 1'b1, lat);
        check("poke_lat", 32'(lat), 32'd5);
        check_pair("poke", 3825, 0, 3825, 0);

        // Overflow: 17 ops fit, 18th wraps / saturates
        do_op(8'd255, 4'd15, 1'b1, 1'b0, lat);
        for (int i = 2; i <= 17; i++) do_op(8'd255, 4'd15, 1'b0, 1'b0, lat);
        check_pair("op17", 65025, 0, 65025, 0);
        do_op(8'd255, 4'd15, 1'b0, 1'b0, lat);
        check_pair("op18", 3314, 1, 65535, 1);
        do_op(8'd1, 4'd1, 1'b0, 1'b0, lat);
        check_pair("op19", 3315, 1, 65535, 1);

        // start held high: a new op on every done edge, B_WIDTH+2 cycles apart
        @(negedge clk);
        a = 8'd3; b = 4'd5; start = 1'b1;
        @(posedge clk);
        edges = 0;
        nd = 0;
        while (nd < 3 && edges < 40) begin
            @(negedge clk);
            if (done_w) begin
                nd++;
                check("held_edge", 32'(edges), 32'(6 * nd - 1));
                check("held_acc_w", 32'(acc_w), 32'(3315 + 15 * nd));
                check("held_acc_s", 32'(acc_s), 32'd65535);
                if (nd == 3) start = 1'b0;
            end
            @(posedge clk);
            edges++;
        end
        check("held_count", 32'(nd), 32'd3);
        @(negedge clk);
        check("held_stop_busy", 32'(busy_w), 32'd0);

        // Reset mid-MUL abandons the op immediately
        a = 8'd200; b = 4'd9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mul_busy_pre_rst", 32'(busy_w), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_acc", 32'(acc_w), 32'd0);
        check("midrst_ovf", 32'(ovf_w), 32'd0);
        check("midrst_busy", 32'(busy_w), 32'd0);
        check("midrst_acc_s", 32'(acc_s), 32'd0);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_w) seen = 1'b1;
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        check("midrst_acc_after", 32'(acc_w), 32'd0);

        // Wider multiplier instance
        do_op6(8'd255, 6'd63, lat);
        check("w6_lat", 32'(lat), 32'd7);
        check("w6_acc", 32'(acc6), 32'd16065);
        do_op6(8'd255, 6'd63, lat);
        check("w6_acc2", 32'(acc6), 32'd32130);
        check("w6_ovf", 32'(ovf6), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_serial_accumulator.md
Name: mac_serial_accumulator

Overview:
- Parametrised successor to the combinational 8+4-bit adder: an unsigned multiply-accumulate unit that multiplies A by B with shift-and-add, one B bit per cycle.
- Adds each product into a wide running accumulator, with selectable wrap or saturate overflow handling.
- Sits between operand sources and the result register bank of the MAC datapath.
- Uses a start/busy/done handshake.

Parameters:
- A_WIDTH, 8, width of multiplicand a (unsigned).
- B_WIDTH, 4, width of multiplier b (unsigned); equals the number of multiply cycles.
- ACC_WIDTH, 16, accumulator width; must be >= A_WIDTH+B_WIDTH.
- SATURATE, 0, 0 = accumulator wraps modulo 2^ACC_WIDTH; 1 = accumulator clamps at 2^ACC_WIDTH-1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request an operation; sampled only when busy=0.
- clear  in  1  zero the accumulator and overflow flag.
- a  in  A_WIDTH  multiplicand; latched on an accepted start.
- b  in  B_WIDTH  multiplier; latched on an accepted start.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when acc has been updated.
- acc  out  ACC_WIDTH  running accumulator value.
- overflow  out  1  sticky flag; set when any accumulate exceeds 2^ACC_WIDTH-1.

Behaviour:
- Reset: asynchronous, effective immediately, also mid-operation. State=IDLE, acc=0, overflow=0, busy=0, done=0, internal a_reg/b_reg/product/count=0. Any operation in flight is abandoned with no done pulse.
- States: IDLE, MUL, ACC.
- IDLE:
  - On start=1, latch a/b, set product=0 and count=0, go to MUL.
  - busy is high from the next edge.
- MUL:
  - Each edge: if b_reg[count]=1, product += a_reg<<count. Product width is A_WIDTH+B_WIDTH and never overflows.
  - Then count += 1. After the edge that processes count=B_WIDTH-1, go to ACC.
  - MUL occupies exactly B_WIDTH cycles.
- ACC (one cycle):
  - On the edge leaving ACC: acc <= base+product, where base = clear ? 0 : acc.
  - If the true sum is > 2^ACC_WIDTH-1: overflow <= 1, and acc <= sum mod 2^ACC_WIDTH (SATURATE=0) or acc <= 2^ACC_WIDTH-1 (SATURATE=1).
  - Same edge: done <= 1, busy <= 0, state <= IDLE.
- Latency: with start accepted at edge 0, done and the updated acc are visible after edge B_WIDTH+1; done drops after edge B_WIDTH+2.
- Back-to-back: a start held while done=1 (busy=0) is accepted at that edge. Sustained throughput is one product per B_WIDTH+2 cycles.
- start while busy=1: ignored entirely; latched operands are not disturbed.
- clear:
  - Honoured on any edge. acc <= 0 and overflow <= 0, except in ACC, where clear replaces the base as above.
  - In MUL it does not affect product or count.
  - clear and start in the same IDLE cycle: clear applies and the operation starts; its result accumulates onto 0.
- Saturated acc stays at the maximum on further accumulates; overflow remains 1 until clear or rst.
- b=0 or a=0: full B_WIDTH+2 cycle sequence still runs; acc is unchanged and done still pulses.
- overflow does not self-clear.

Test Plan:
- Reset values: rst pulse mid-cycle with no clk edge -> acc=0, overflow=0, busy=0, done=0 immediately. rst asserted during MUL (a=200, b=9) -> no done pulse, acc stays 0.
- Single op, defaults: a=255, b=15, start at edge 0 -> busy=1 over edges 1..5, done=1 for one cycle after edge 5, acc=3825, overflow=0.
- Accumulate and clear: ops (12,3), (7,15), (0,9) -> acc=36, 141, 141, done pulsing each time. clear in IDLE -> acc=0. clear+start with (2,2) -> acc=4.
- Wrap (SATURATE=0): 18 ops of (255,15) -> after op 17 acc=65025, overflow=0; after op 18 acc=3314, overflow=1. Overflow stays 1 through a further (1,1) op (acc=3315).
- Saturate (SATURATE=1): same 18 ops -> acc=65535, overflow=1; a 19th op leaves acc=65535.
- Handshake corners:
  - start pulsed during MUL with a=1, b=1 -> ignored; original (255,15) result 3825 is unaffected.
  - start held high continuously -> new op accepted on each done edge; every op spans B_WIDTH+2 cycles.
  - Repeat the single op with B_WIDTH=6, ACC_WIDTH=24 using a=255, b=63 -> done after edge 7, acc=16065.
